oflow_mem_buffer_wr_ctrl: RTL and testbench

OFLOW_MEM_BUFFER_WR_CTRL -- requirements
Module: oflow_mem_buffer_wr_ctrl

---
 rtl/oflow_mem_buffer_wr_ctrl_pkg.sv | 19 +
 rtl/oflow_mem_buffer_wr_ctrl_if.sv | 26 ++
 rtl/oflow_group_serializer.sv | 41 ++++
 rtl/oflow_mem_buffer_wr_ctrl.sv | 122 ++++++++++++
 tb/tb_oflow_mem_buffer_wr_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oflow_mem_buffer_wr_ctrl_pkg.sv
// Shared definitions for the oflow buffer write controller: FSM state
// encoding, the fixed group size and the remainder-to-count decode.
package oflow_mem_buffer_wr_ctrl_pkg;

  localparam int OFLOW_GROUP = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  // A remainder of 0 means a full group of four words.
  function automatic logic [2:0] rem_to_count(input logic [1:0] rem);
    return (rem == 2'd0) ? 3'd4 : {1'b0, rem};
  endfunction

endpackage

// File: rtl/oflow_mem_buffer_wr_ctrl_if.sv
// Core-to-buffer bus: PE result groups in, buffer memory writes out.
// The controller is the master of the memory write port.
interface oflow_mem_buffer_wr_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int GROUP  = 4
);

  logic                      ready_from_core;
  logic [1:0]                remainder;
  logic [GROUP*DATA_W-1:0]   data_in;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;

  modport master (
    input  ready_from_core, remainder, data_in,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output ready_from_core, remainder, data_in,
    input  wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/oflow_group_serializer.sv
// Holds one accepted group of PE words and presents them one at a time,
// flagging the last valid word of the group.
module oflow_group_serializer
  import oflow_mem_buffer_wr_ctrl_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int GROUP  = OFLOW_GROUP
) (
  input  logic                    clk,
  input  logic                    reset_N,
  input  logic                    load,
  input  logic                    advance,
  input  logic [1:0]              remainder,
  input  logic [GROUP*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]       word,
  output logic                    last_word
);

  logic [GROUP-1:0][DATA_W-1:0] grp_q;
  logic [1:0]                   idx_q;
  logic [2:0]                   count_q;

  // Capture a new group on load (which wins over advance), else step the word index.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      grp_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else if (load) begin
      grp_q   <= data_in;
      idx_q   <= '0;
      count_q <= rem_to_count(remainder);
    end else if (advance) begin
      idx_q   <= idx_q + 2'd1;
    end
  end

  assign word      = grp_q[idx_q];
  assign last_word = ({1'b0, idx_q} == (count_q - 3'd1));

endmodule

// File: rtl/oflow_mem_buffer_wr_ctrl.sv
// Writes a frame's worth of PE result words into the buffer memory,
// one word per cycle, accepting groups of up to four words from the core.
module oflow_mem_buffer_wr_ctrl
  import oflow_mem_buffer_wr_ctrl_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int NBB_W  = 10,
  parameter int GROUP  = OFLOW_GROUP
) (
  input  logic                  clk,
  input  logic                  reset_N,
  input  logic                  start_frame,
  input  logic [NBB_W-1:0]      num_of_bbox_in_frame,
  oflow_mem_buffer_wr_ctrl_if.master bus,
  output logic                  done_write_buffer,
  output logic                  busy,
  output logic                  overrun_err
);

  wr_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [NBB_W-1:0]   written_q, written_d;
  logic [NBB_W-1:0]   total_q, total_d;
  logic               overrun_q, overrun_d;
  logic               accept, advance;
  logic               total_hit, last_write, violation;
  logic               wr_en;
  logic [DATA_W-1:0]  ser_word;
  logic               ser_last;

  oflow_group_serializer #(
    .DATA_W (DATA_W),
    .GROUP  (GROUP)
  ) u_serializer (
    .clk       (clk),
    .reset_N   (reset_N),
    .load      (accept),
    .advance   (advance),
    .remainder (bus.remainder),
    .data_in   (bus.data_in),
    .word      (ser_word),
    .last_word (ser_last)
  );

  // A group ends on its last valid word or when the frame total is reached.
  assign total_hit  = (written_q == (total_q - NBB_W'(1)));
  assign last_write = (state_q == ST_WRITE) && (ser_last || total_hit);
  assign violation  = bus.ready_from_core &&
                      (start_frame || (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                       ((state_q == ST_WRITE) && !last_write));

  // Frame sequencing: start_frame always re-arms, otherwise walk the group words.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    written_d = written_q;
    total_d   = total_q;
    overrun_d = overrun_q | violation;
    accept    = 1'b0;
    advance   = 1'b0;
    if (start_frame) begin
      addr_d    = '0;
      written_d = '0;
      total_d   = num_of_bbox_in_frame;
      overrun_d = bus.ready_from_core;
      state_d   = (num_of_bbox_in_frame == '0) ? ST_DONE : ST_ARMED;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_ARMED: begin
          if (bus.ready_from_core) begin
            accept  = 1'b1;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          advance   = 1'b1;
          addr_d    = addr_q + ADDR_W'(1);
          written_d = written_q + NBB_W'(1);
          if (last_write) begin
            if (total_hit) begin
              state_d = ST_DONE;
            end else if (bus.ready_from_core) begin
              accept = 1'b1;
            end else begin
              state_d = ST_ARMED;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and frame bookkeeping registers.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      written_q <= '0;
      total_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      written_q <= written_d;
      total_q   <= total_d;
      overrun_q <= overrun_d;
    end
  end

  assign wr_en             = (state_q == ST_WRITE);
  assign bus.wr_en         = wr_en;
  assign bus.wr_addr       = addr_q;
  assign bus.wr_data       = wr_en ? ser_word : '0;
  assign done_write_buffer = (state_q == ST_DONE);
  assign busy              = (state_q != ST_IDLE);
  assign overrun_err       = overrun_q;

endmodule

// File: tb/tb_oflow_mem_buffer_wr_ctrl.sv
// Testbench for oflow_mem_buffer_wr_ctrl: frames are planned as a timeline of
// ready pulses and the expected buffer writes are derived from that plan.
module tb_oflow_mem_buffer_wr_ctrl;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 3;
  localparam int NBB_W  = 10;
  localparam int GROUP  = 4;
  localparam int MAXG   = 32;

  logic             clk;
  logic             reset_N;
  logic             start_frame;
  logic [NBB_W-1:0] num_of_bbox_in_frame;
  logic             done_write_buffer;
  logic             busy;
  logic             overrun_err;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t wr_log[$];
  wr_t exp_q[$];
  int  done_log[$];
  int  exp_done;

  logic [GROUP*DATA_W-1:0] plan_data [MAXG];
  int plan_rem   [MAXG];
  int plan_extra [MAXG];
  int rdy_cyc    [MAXG];
  int plan_first;

  oflow_mem_buffer_wr_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .GROUP(GROUP)) bus ();

  oflow_mem_buffer_wr_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NBB_W  (NBB_W),
    .GROUP  (GROUP)
  ) dut (
    .clk                  (clk),
    .reset_N              (reset_N),
    .start_frame          (start_frame),
    .num_of_bbox_in_frame (num_of_bbox_in_frame),
    .bus                  (bus),
    .done_write_buffer    (done_write_buffer),
    .busy                 (busy),
    .overrun_err          (overrun_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle number: cycle n is the interval following the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every buffer write and done pulse mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) wr_log.push_back('{cyc, bus.wr_addr, bus.wr_data});
    if (done_write_buffer === 1'b1) done_log.push_back(cyc);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [GROUP*DATA_W-1:0] rand_group();
    logic [GROUP*DATA_W-1:0] v;
    for (int j = 0; j < GROUP*DATA_W/32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: walk the planned groups, taking min(group count, words left)
  // words from each; write i lands at address i mod 2^ADDR_W.
  task automatic plan_frame(input int num, input int s, output int ng);
    int remaining, rc, a, c;
    exp_q.delete();
    remaining = num;
    rc        = s + 1 + plan_first;
    a         = 0;
    ng        = 0;
    exp_done  = s + 1;
    while (remaining > 0 && ng < MAXG) begin
      c = (plan_rem[ng] == 0) ? 4 : plan_rem[ng];
      if (c > remaining) c = remaining;
      rdy_cyc[ng] = rc;
      for (int k = 0; k < c; k++) begin
        exp_q.push_back('{rc + 1 + k, ADDR_W'(a % (2**ADDR_W)), plan_data[ng][k*DATA_W +: DATA_W]});
        a++;
      end
      exp_done  = rc + c + 1;
      remaining = remaining - c;
      rc        = rc + c + plan_extra[ng];
      ng++;
    end
  endtask

  // Drive one frame following the plan arrays, then wait for done (bounded).
  task automatic apply_frame(input int num);
    int s, ng, gi;
    wr_log.delete();
    done_log.delete();
    @(posedge clk); #1;
    start_frame          = 1'b1;
    num_of_bbox_in_frame = NBB_W'(num);
    s                    = cyc;
    plan_frame(num, s, ng);
    @(posedge clk); #1;
    start_frame = 1'b0;
    gi = 0;
    while (gi < ng) begin
      if (cyc == rdy_cyc[gi]) begin
        bus.ready_from_core = 1'b1;
        bus.remainder       = 2'(plan_rem[gi]);
        bus.data_in         = plan_data[gi];
        gi++;
      end else begin
        bus.ready_from_core = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.ready_from_core = 1'b0;
    for (int w = 0; w < 40 && done_log.size() == 0; w++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_N = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0 ||
        done_write_buffer !== 1'b0 || busy !== 1'b0 || overrun_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got wr_en=%b addr=%0d data=%h done=%b busy=%b ovr=%b want all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, done_write_buffer, busy, overrun_err);
    end
    @(posedge clk); #1;
    reset_N = 1'b1;
    @(posedge clk); #1;
  endtask

  // Back-to-back groups with no bubble, including address wrap at 2^ADDR_W.
  task automatic test_back_to_back();
    int nums [2] = '{8, 12};
    string tag;
    for (int t = 0; t < 2; t++) begin
      tag = $sformatf("b2b_num%0d", nums[t]);
      plan_first = 0;
      for (int g = 0; g < MAXG; g++) begin
        plan_rem[g]   = 0;
        plan_extra[g] = (t == 1 && g == 1) ? 2 : 0;
        plan_data[g]  = rand_group();
      end
      apply_frame(nums[t]);
      total++;
      if (wr_log.size() != exp_q.size()) begin
        bad++;
        $display("[TB] FAIL %s write_count got=%0d want=%0d", tag, wr_log.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
        total++;
        if (wr_log[i].cyc != exp_q[i].cyc || wr_log[i].addr !== exp_q[i].addr || wr_log[i].data !== exp_q[i].data) begin
          bad++;
          $display("[TB] FAIL %s write%0d got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h", tag, i,
                   wr_log[i].cyc, wr_log[i].addr, wr_log[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
        end
      end
      total++;
      if (done_log.size() != 1 || done_log[0] != exp_done) begin
        bad++;
        $display("[TB] FAIL %s done_pulse got count=%0d want one pulse at cyc=%0d", tag, done_log.size(), exp_done);
      end
    end
  endtask

  // Frame total reached mid-group: trailing words must be dropped.
  task automatic test_truncation();
    int nums [2] = '{6, 3};
    string tag;
    for (int t = 0; t < 2; t++) begin
      tag = $sformatf("trunc_num%0d", nums[t]);
      plan_first = 1;
      for (int g = 0; g < MAXG; g++) begin
        plan_rem[g]   = (t == 0 && g == 1) ? 2 : 0;
        plan_extra[g] = 2;
        plan_data[g]  = rand_group();
      end
      apply_frame(nums[t]);
      total++;
      if (wr_log.size() != exp_q.size()) begin
        bad++;
        $display("[TB] FAIL %s write_count got=%0d want=%0d", tag, wr_log.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
        total++;
        if (wr_log[i].cyc != exp_q[i].cyc || wr_log[i].addr !== exp_q[i].addr || wr_log[i].data !== exp_q[i].data) begin
          bad++;
          $display("[TB] FAIL %s write%0d got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h", tag, i,
                   wr_log[i].cyc, wr_log[i].addr, wr_log[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
        end
      end
      total++;
      if (done_log.size() != 1 || done_log[0] != exp_done) begin
        bad++;
        $display("[TB] FAIL %s done_pulse got count=%0d want one pulse at cyc=%0d", tag, done_log.size(), exp_done);
      end
      total++;
      if (busy !== 1'b0 || overrun_err !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s idle_after got busy=%b ovr=%b want 0 0", tag, busy, overrun_err);
      end
    end
  endtask

  task automatic test_zero_count();
    plan_first = 0;
    apply_frame(0);
    total++;
    if (wr_log.size() != 0) begin
      bad++;
      $display("[TB] FAIL zero_count writes got=%0d want=0", wr_log.size());
    end
    total++;
    if (done_log.size() != 1 || done_log[0] != exp_done) begin
      bad++;
      $display("[TB] FAIL zero_count done_pulse got count=%0d want one pulse at cyc=%0d", done_log.size(), exp_done);
    end
  endtask

  task automatic test_random_frames();
    int num;
    string tag;
    for (int f = 0; f < 25; f++) begin
      tag = $sformatf("rand%0d", f);
      num = $urandom_range(20, 1);
      plan_first = $urandom_range(2, 0);
      for (int g = 0; g < MAXG; g++) begin
        plan_rem[g]   = $urandom_range(3, 0);
        plan_extra[g] = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(3, 1);
        plan_data[g]  = rand_group();
      end
      apply_frame(num);
      total++;
      if (wr_log.size() != exp_q.size()) begin
        bad++;
        $display("[TB] FAIL %s write_count got=%0d want=%0d", tag, wr_log.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
        total++;
        if (wr_log[i].cyc != exp_q[i].cyc || wr_log[i].addr !== exp_q[i].addr || wr_log[i].data !== exp_q[i].data) begin
          bad++;
          $display("[TB] FAIL %s write%0d got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h", tag, i,
                   wr_log[i].cyc, wr_log[i].addr, wr_log[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
        end
      end
      total++;
      if (done_log.size() != 1 || done_log[0] != exp_done) begin
        bad++;
        $display("[TB] FAIL %s done_pulse got count=%0d want one pulse at cyc=%0d", tag, done_log.size(), exp_done);
      end
      total++;
      if (overrun_err !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s overrun got=%b want=0", tag, overrun_err);
      end
    end
  endtask

  task automatic test_overrun();
    logic [GROUP*DATA_W-1:0] grp;
    int r;
    // ready while idle
    @(posedge clk); #1;
    bus.ready_from_core = 1'b1;
    @(posedge clk); #1;
    bus.ready_from_core = 1'b0;
    @(negedge clk);
    total++;
    if (overrun_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovr_idle got=%b want=1", overrun_err);
    end
    // start_frame clears the flag
    @(posedge clk); #1;
    start_frame = 1'b1;
    num_of_bbox_in_frame = NBB_W'(8);
    @(posedge clk); #1;
    start_frame = 1'b0;
    wr_log.delete();
    done_log.delete();
    total++;
    if (overrun_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovr_cleared got ovr=%b busy=%b want 0 1", overrun_err, busy);
    end
    // one full group, then a stray pulse in the second write cycle
    grp = rand_group();
    r = cyc;
    bus.ready_from_core = 1'b1;
    bus.remainder       = 2'd0;
    bus.data_in         = grp;
    @(posedge clk); #1;
    bus.ready_from_core = 1'b0;
    @(posedge clk); #1;
    bus.ready_from_core = 1'b1;
    bus.data_in         = rand_group();
    @(posedge clk); #1;
    bus.ready_from_core = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++;
    if (overrun_err !== 1'b1 || busy !== 1'b1 || done_log.size() != 0) begin
      bad++;
      $display("[TB] FAIL ovr_write got ovr=%b busy=%b done=%0d want 1 1 0", overrun_err, busy, done_log.size());
    end
    total++;
    if (wr_log.size() != 4) begin
      bad++;
      $display("[TB] FAIL ovr_write_count got=%0d want=4", wr_log.size());
    end
    for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
      total++;
      if (wr_log[k].cyc != r + 1 + k || wr_log[k].addr !== ADDR_W'(k) || wr_log[k].data !== grp[k*DATA_W +: DATA_W]) begin
        bad++;
        $display("[TB] FAIL ovr_write%0d got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h", k,
                 wr_log[k].cyc, wr_log[k].addr, wr_log[k].data, r + 1 + k, k, grp[k*DATA_W +: DATA_W]);
      end
    end
    // ready coinciding with start_frame: flagged and ignored
    @(posedge clk); #1;
    wr_log.delete();
    start_frame = 1'b1;
    num_of_bbox_in_frame = NBB_W'(5);
    bus.ready_from_core = 1'b1;
    @(posedge clk); #1;
    start_frame = 1'b0;
    bus.ready_from_core = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (overrun_err !== 1'b1 || busy !== 1'b1 || wr_log.size() != 0) begin
      bad++;
      $display("[TB] FAIL ovr_with_start got ovr=%b busy=%b writes=%0d want 1 1 0", overrun_err, busy, wr_log.size());
    end
    // a fresh empty frame clears it again
    @(posedge clk); #1;
    start_frame = 1'b1;
    num_of_bbox_in_frame = NBB_W'(0);
    @(posedge clk); #1;
    start_frame = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (overrun_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ovr_restart got ovr=%b busy=%b want 0 0", overrun_err, busy);
    end
  endtask

  task automatic test_reset_mid_write();
    @(posedge clk); #1;
    start_frame = 1'b1;
    num_of_bbox_in_frame = NBB_W'(8);
    @(posedge clk); #1;
    start_frame = 1'b0;
    bus.ready_from_core = 1'b1;
    bus.remainder       = 2'd0;
    bus.data_in         = rand_group();
    @(posedge clk); #1;
    bus.ready_from_core = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(1)) begin
      bad++;
      $display("[TB] FAIL midwrite_pre got wr_en=%b addr=%0d want 1 1", bus.wr_en, bus.wr_addr);
    end
    reset_N = 1'b0;
    #1;
    total++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0 ||
        done_write_buffer !== 1'b0 || busy !== 1'b0 || overrun_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midwrite_reset got wr_en=%b addr=%0d data=%h done=%b busy=%b ovr=%b want all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, done_write_buffer, busy, overrun_err);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_N = 1'b1;
    wr_log.delete();
    done_log.delete();
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (wr_log.size() != 0 || done_log.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midwrite_after got writes=%0d done=%0d busy=%b want 0 0 0", wr_log.size(), done_log.size(), busy);
    end
  endtask

  initial begin
    reset_N              = 1'b0;
    start_frame          = 1'b0;
    num_of_bbox_in_frame = '0;
    bus.ready_from_core  = 1'b0;
    bus.remainder        = 2'd0;
    bus.data_in          = '0;
    test_reset();
    test_back_to_back();
    test_truncation();
    test_zero_count();
    test_random_frames();
    test_overrun();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
